// File: rtl/alpha_block.sv
// alpha_block: word-serial CIOS alpha step, T_out = T_in + ai*b over S+2 words.
// Ports:
//   clk    - sole clock, all state changes on its rising edge
//   rst_n  - asynchronous active-low reset
//   flush  - synchronous abort-and-clear, overrides everything else
//   start  - request one pass, accepted only in IDLE or DONE
//   ai     - multiplier word, sampled on accepted start
//   b      - S multiplicand words (word 0 in the low bits), sampled on accepted start
//   T_in   - S+2 accumulator words (word 0 in the low bits), sampled on accepted start
//   busy   - high in MAC and FINAL
//   done   - level, high while T_out holds a completed result
//   T_out  - registered S+2 word accumulator
module alpha_block #(
    parameter int WIDTH = 32,
    parameter int S     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     start,
    input  logic [WIDTH-1:0]         ai,
    input  logic [S*WIDTH-1:0]       b,
    input  logic [(S+2)*WIDTH-1:0]   T_in,
    output logic                     busy,
    output logic                     done,
    output logic [(S+2)*WIDTH-1:0]   T_out
);
    localparam int JW = $clog2(S);
    typedef enum logic [1:0] {IDLE, MAC, FINAL, DONE} state_t;
    state_t             state_q;
    logic [WIDTH-1:0]   ai_q;
    logic [WIDTH-1:0]   c_q;
    logic [S*WIDTH-1:0] b_q;
    logic [WIDTH-1:0]   t_q [S+2];
    logic [JW-1:0]      j_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   t_sel_d;
    logic [2*WIDTH-1:0] mac_d;
    logic [WIDTH:0]     fin_d;
    // Current accumulator word T[j]
    always_comb begin
        t_sel_d = '0;
        for (int i = 0; i < S; i++)
            if (JW'(i) == j_q) t_sel_d = t_q[i];
    end
    // b is consumed by shifting, so the active multiplicand word is always the low word.
    // The 2*WIDTH sum T + a*b + C is at most 2^(2*WIDTH)-1, so it cannot overflow.
    assign mac_d = (2*WIDTH)'(t_sel_d) + (2*WIDTH)'(ai_q) * (2*WIDTH)'(b_q[WIDTH-1:0]) + (2*WIDTH)'(c_q);
    assign fin_d = (WIDTH+1)'(t_q[S]) + (WIDTH+1)'(c_q);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ai_q    <= '0;
            b_q     <= '0;
            c_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < S+2; i++) t_q[i] <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            c_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < S+2; i++) t_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        ai_q    <= ai;
                        b_q     <= b;
                        c_q     <= '0;
                        j_q     <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= MAC;
                        for (int i = 0; i < S+2; i++) t_q[i] <= T_in[i*WIDTH +: WIDTH];
                    end
                end
                MAC: begin
                    for (int i = 0; i < S; i++)
                        if (JW'(i) == j_q) t_q[i] <= mac_d[WIDTH-1:0];
                    c_q <= mac_d[2*WIDTH-1:WIDTH];
                    b_q <= b_q >> WIDTH;
                    j_q <= j_q + 1'b1;
                    if (j_q == JW'(S-1)) state_q <= FINAL;
                end
                FINAL: begin
                    t_q[S]   <= fin_d[WIDTH-1:0];
                    t_q[S+1] <= t_q[S+1] + WIDTH'(fin_d[WIDTH]);
                    c_q      <= '0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    for (genvar g = 0; g < S+2; g++) begin : g_out
        assign T_out[g*WIDTH +: WIDTH] = t_q[g];
    end
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_alpha_block.sv
// tb_alpha_block: self-checking bench for alpha_block with S=4, WIDTH=32.
module tb_alpha_block;
    localparam int W = 32;
    localparam int S = 4;
    logic               clk;
    logic               rst_n;
    logic               flush;
    logic               start;
    logic [W-1:0]       ai;
    logic [S*W-1:0]     b;
    logic [(S+2)*W-1:0] T_in;
    logic               busy;
    logic               done;
    logic [(S+2)*W-1:0] T_out;
    int passed = 0;
    int total  = 0;

    alpha_block #(.WIDTH(W), .S(S)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .start(start),
        .ai(ai), .b(b), .T_in(T_in),
        .busy(busy), .done(done), .T_out(T_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [191:0] rnd192();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: the whole (S+2)-word accumulator as one integer, modulo 2^192
    function automatic logic [191:0] model(input logic [31:0] a, input logic [127:0] bb, input logic [191:0] t);
        return t + 192'(a) * 192'(bb);
    endfunction

    // Issue start at cycle 0, scramble the operand inputs afterwards, check busy over
    // cycles 1..S+1 and done at S+2; returns T_out seen in cycle S+2.
    task automatic pass(input string tag, input logic [31:0] a, input logic [127:0] bb,
                        input logic [191:0] t, output logic [191:0] res);
        ai = a; b = bb; T_in = t; start = 1'b1;
        tick();
        start = 1'b0; ai = $urandom; b = rnd128(); T_in = rnd192();
        for (int c = 1; c <= S+1; c++) begin
            chk({tag, "_busy"}, 192'(busy), 192'(1));
            chk({tag, "_done_low"}, 192'(done), 192'(0));
            tick();
        end
        chk({tag, "_done"}, 192'(done), 192'(1));
        chk({tag, "_busy_low"}, 192'(busy), 192'(0));
        chk({tag, "_T_out"}, T_out, model(a, bb, t));
        res = T_out;
    endtask

    logic [191:0] res;
    logic [191:0] prev;
    logic [31:0]  ra;
    logic [127:0] rb;
    logic [191:0] rt;

    initial begin
        rst_n = 1'b0; flush = 1'b0; start = 1'b0; ai = '0; b = '0; T_in = '0;
        tick();
        tick();
        chk("rst_busy", 192'(busy), 192'(0));
        chk("rst_done", 192'(done), 192'(0));
        chk("rst_T_out", T_out, 192'(0));
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_idle_busy", 192'(busy), 192'(0));
        chk("post_rst_idle_done", 192'(done), 192'(0));

        // Simple pass
        pass("simple", 32'h1, {32'd4, 32'd3, 32'd2, 32'd1}, 192'(0), res);
        chk("simple_lit", res, {32'h0, 32'h0, 32'h4, 32'h3, 32'h2, 32'h1});

        // Full carry ripple
        pass("ripple", 32'hFFFF_FFFF, {4{32'hFFFF_FFFF}}, {32'h0, {5{32'hFFFF_FFFF}}}, res);
        chk("ripple_lit", res, {32'h1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0});

        // Random passes, then back-to-back accumulation starting in the done-rise cycle
        for (int k = 0; k < 6; k++) begin
            ra = $urandom; rb = rnd128(); rt = rnd192();
            pass("rand", ra, rb, rt, res);
        end
        prev = res;
        for (int k = 0; k < 3; k++) begin
            ra = $urandom; rb = rnd128();
            pass("b2b", ra, rb, prev, res);
            prev = res;
        end

        // Flush at cycle 2
        ai = $urandom; b = rnd128(); T_in = rnd192(); start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", 192'(busy), 192'(0));
        chk("flush_done", 192'(done), 192'(0));
        chk("flush_T_out", T_out, 192'(0));
        for (int c = 0; c < 6; c++) begin
            chk("flush_no_done", 192'(done), 192'(0));
            tick();
        end

        // Start during MAC is ignored
        ai = 32'h1; b = {32'd4, 32'd3, 32'd2, 32'd1}; T_in = '0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        ai = $urandom | 32'h2; b = rnd128(); T_in = rnd192(); start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("ign_done", 192'(done), 192'(1));
        chk("ign_T_out", T_out, {32'h0, 32'h0, 32'h4, 32'h3, 32'h2, 32'h1});

        // start and flush together from DONE
        ai = $urandom; b = rnd128(); T_in = rnd192(); start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("sf_busy", 192'(busy), 192'(0));
        chk("sf_done", 192'(done), 192'(0));
        chk("sf_T_out", T_out, 192'(0));
        tick();
        chk("sf_no_pass", 192'(busy), 192'(0));

        // Asynchronous reset mid-MAC
        ai = $urandom; b = rnd128(); T_in = rnd192() | 192'h1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("pre_rst_busy", 192'(busy), 192'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 192'(busy), 192'(0));
        chk("arst_done", 192'(done), 192'(0));
        chk("arst_T_out", T_out, 192'(0));
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("arst_idle_busy", 192'(busy), 192'(0));
            chk("arst_idle_done", 192'(done), 192'(0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
